alu_gf_seq: RTL and testbench
=============================

# alu_gf_seq

Sequential, parametrised successor to the combinational 4-bit ALU. Adds subtraction, shifts, byte rotation and a multi-cycle GF(2^8) multiply (AES polynomial 0x11B, applied per byte lane), with carry and zero flags. It sits behind valid/ready handshakes so the AES datapath (MixColumns, key schedule) and control logic can share one arithmetic unit.

## Interface
- WIDTH, 8, operand/result width in bits; must be a multiple of 8 and ≥ 8. Elaboration fails otherwise. LANES = WIDTH/8.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- operand_a  in  WIDTH  first operand
- operand_b  in  WIDTH  second operand / shift amount / GF multiplier
- alu_op  in  3  operation select
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- carry  out  1  ADD carry-out / SUB borrow; 0 for all other ops
- busy  out  1  high while state ≠ IDLE

## Operation
- alu_op: 000 AND, 001 OR, 010 XOR, 011 ADD (mod 2^WIDTH), 100 SUB (a−b mod 2^WIDTH), 101 SHL (a << b[clog2(WIDTH)−1:0], zero fill), 110 ROTL8 (a rotated left by 8 bits; identity when WIDTH=8), 111 GFMUL (per lane: result byte i = a byte i • b byte i in GF(2^8), mod 0x11B).
- Operands and alu_op are captured on acceptance (in_valid && in_ready). Inputs are ignored at all other times.
- FSM has three states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On acceptance, ops 000–110 go to DONE with result computed. GFMUL goes to BUSY, count=0, accumulator=0.
  - BUSY: each cycle, for every lane: if b bit[count] is set, acc ^= a_shift. Then a_shift = xtime(a_shift), i.e. shift left 1 and XOR 0x1B on carry-out of bit 7. count++. After the count=7 cycle, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- One request is outstanding at a time. in_ready=0 in BUSY and DONE.
- carry: ADD = bit WIDTH of a+b. SUB = 1 when a < b (unsigned). Otherwise 0.
- zero and carry are registered together with result.

## Timing
- Reset (async assert, sync-safe deassert handled externally): state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, carry=0, busy=0. Reset mid-BUSY or mid-DONE aborts the operation and drops the result.
- Latency from acceptance edge to out_valid high:
  - 1 clock for ops 000–110.
  - 9 clocks for GFMUL (8 BUSY cycles + DONE).
- Throughput: one op per 2 clocks (single-cycle ops); one per 10 clocks (GFMUL), assuming out_ready=1.
- Backpressure: while out_valid && !out_ready, result, zero and carry are held stable. No new request is accepted.
- in_ready returns high the cycle after the out_valid && out_ready handshake. There is no same-cycle accept-on-drain.
- in_valid asserted while in_ready=0 has no effect. The requester keeps it asserted until accepted.
- Lanes are independent. There is no carry or reduction across byte boundaries in GFMUL. ADD/SUB/SHL operate across full WIDTH.

## Test plan
- WIDTH=8, GFMUL a=0x57 b=0x83 → after 9 clocks: result=0xC1, zero=0, carry=0. Also a=0x57 b=0x13 → 0xFE.
- WIDTH=8, ADD 0xF0+0x20 → 0x10, carry=1 at 1 clock. SUB 0x05−0x07 → 0xFE, carry=1. SUB 0x07−0x07 → 0x00, zero=1, carry=0.
- WIDTH=16:
  - GFMUL a=0x5702 b=0x8387 → 0xC115 (lane-independent).
  - ROTL8 0x1234 → 0x3412.
  - SHL a=0x0001 b=0x0013 → 0x0008 (amount taken mod 16).
- Backpressure: XOR 0xAA^0xAA with out_ready=0 for 5 clocks → out_valid and result=0x00/zero=1 held, in_ready=0 throughout, second in_valid ignored. Release out_ready → in_ready high the following clock.
- Reset mid-op: assert rst_n=0 at BUSY count=4 of GFMUL → immediately state IDLE, out_valid=0, result=0. Next GFMUL 0x02•0x87 → 0x15 correct.
- Back-to-back: 8 random ops of every alu_op with out_ready=1 are checked against the reference model. Each op's out_valid is a single-clock pulse at the stated latency.

Source files
------------

// File: rtl/alu_gf_seq_if.sv
// Request/response bundle for alu_gf_seq.
// The master drives operands and accepts results; the slave is the ALU.
interface alu_gf_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [2:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             busy;

  modport master (
    output in_valid, operand_a, operand_b, alu_op, out_ready,
    input  in_ready, out_valid, result, zero, carry, busy
  );

  modport slave (
    input  in_valid, operand_a, operand_b, alu_op, out_ready,
    output in_ready, out_valid, result, zero, carry, busy
  );
endinterface

// File: rtl/alu_gf_seq.sv
// Sequential ALU with valid/ready handshakes: logic/arith/shift ops in one
// cycle, per-byte GF(2^8) multiply (poly 0x11B) over eight BUSY cycles.
module alu_gf_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  alu_gf_seq_if.slave bus
);
  localparam int unsigned LANES = WIDTH / 8;
  localparam int unsigned SHW   = $clog2(WIDTH);

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("alu_gf_seq: WIDTH must be a multiple of 8 and >= 8");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_a_shift;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_count;

  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_rot;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_ash_nxt;

  always_comb begin
    w_sum   = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    // Upper half of the doubled word shifted by 8 is a rotate-left-by-8;
    // degenerates to identity when WIDTH is 8.
    w_rot   = {bus.operand_a, bus.operand_a} << 8;
    w_res   = '0;
    w_carry = 1'b0;
    case (bus.alu_op)
      3'b000: w_res = bus.operand_a & bus.operand_b;
      3'b001: w_res = bus.operand_a | bus.operand_b;
      3'b010: w_res = bus.operand_a ^ bus.operand_b;
      3'b011: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      3'b100: begin
        w_res   = bus.operand_a - bus.operand_b;
        w_carry = bus.operand_a < bus.operand_b;
      end
      3'b101: w_res = bus.operand_a << bus.operand_b[SHW-1:0];
      3'b110: w_res = w_rot[2*WIDTH-1:WIDTH];
      default: w_res = '0;
    endcase
  end

  // One shift-and-add step of the GF multiply, independently per byte lane.
  always_comb begin
    w_acc_nxt = '0;
    w_ash_nxt = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_acc_nxt[l*8 +: 8] = r_acc[l*8 +: 8] ^
                            (r_b[l*8 + 32'(r_count)] ? r_a_shift[l*8 +: 8] : 8'h00);
      w_ash_nxt[l*8 +: 8] = {r_a_shift[l*8 +: 7], 1'b0} ^
                            (r_a_shift[l*8 + 7] ? 8'h1B : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_acc       <= '0;
      r_a_shift   <= '0;
      r_b         <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (bus.alu_op == 3'b111) begin
              r_state   <= BUSY;
              r_a_shift <= bus.operand_a;
              r_b       <= bus.operand_b;
              r_acc     <= '0;
              r_count   <= '0;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_zero      <= (w_res == '0);
              r_carry     <= w_carry;
            end
          end
        end
        BUSY: begin
          r_acc     <= w_acc_nxt;
          r_a_shift <= w_ash_nxt;
          r_count   <= r_count + 3'd1;
          if (r_count == 3'd7) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_acc_nxt;
            r_zero      <= (w_acc_nxt == '0);
            r_carry     <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.carry     = r_carry;
endmodule

// File: tb/tb_alu_gf_seq.sv
// Self-checking bench for alu_gf_seq at WIDTH=8 and WIDTH=16 against an
// arithmetic reference model (carry-less product + polynomial reduction).
module tb_alu_gf_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  alu_gf_seq_if #(.WIDTH(8))  if8 ();
  alu_gf_seq_if #(.WIDTH(16)) if16 ();

  alu_gf_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  alu_gf_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

  int unsigned cur_w = 8;
  logic        t_ivalid, t_ordy;
  logic [15:0] t_a, t_b;
  logic [2:0]  t_op;

  assign if8.in_valid   = t_ivalid && (cur_w == 8);
  assign if8.operand_a  = t_a[7:0];
  assign if8.operand_b  = t_b[7:0];
  assign if8.alu_op     = t_op;
  assign if8.out_ready  = t_ordy;
  assign if16.in_valid  = t_ivalid && (cur_w == 16);
  assign if16.operand_a = t_a;
  assign if16.operand_b = t_b;
  assign if16.alu_op    = t_op;
  assign if16.out_ready = t_ordy;

  logic [15:0] m_res;
  logic        m_ov, m_ir, m_z, m_c, m_busy;
  always_comb begin
    if (cur_w == 16) begin
      m_res = if16.result; m_ov = if16.out_valid; m_ir = if16.in_ready;
      m_z = if16.zero; m_c = if16.carry; m_busy = if16.busy;
    end else begin
      m_res = {8'h00, if8.result}; m_ov = if8.out_valid; m_ir = if8.in_ready;
      m_z = if8.zero; m_c = if8.carry; m_busy = if8.busy;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        c;
    logic        z;
    logic [15:0] res;
  } exp_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (16'h011B << (k - 8));
    return p[7:0];
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input int unsigned w);
    int unsigned mask, ua, ub, r;
    exp_t e;
    mask = (w == 16) ? 32'hFFFF : 32'hFF;
    ua = 32'(a) & mask;
    ub = 32'(b) & mask;
    r  = 0;
    e.c = 1'b0;
    case (op)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd2: r = ua ^ ub;
      3'd3: begin r = (ua + ub) & mask; e.c = (ua + ub) > mask; end
      3'd4: begin r = (ua - ub) & mask; e.c = ua < ub; end
      3'd5: r = (ua << (ub % w)) & mask;
      3'd6: r = (w == 8) ? ua : (((ua << 8) | (ua >> (w - 8))) & mask);
      default:
        for (int unsigned l = 0; l < w / 8; l++)
          r = r | (32'(gf_mul(8'(ua >> (8 * l)), 8'(ub >> (8 * l)))) << (8 * l));
    endcase
    e.res = 16'(r);
    e.z   = (r == 0);
    return e;
  endfunction

  task automatic run(input int unsigned w, input logic [2:0] op,
                     input logic [15:0] a, input logic [15:0] b, input string tag);
    exp_t e;
    int unsigned lat;
    e = model(op, a, b, w);
    cur_w = w; t_op = op; t_a = a; t_b = b; t_ordy = 1'b1; t_ivalid = 1'b1;
    #0;
    chk({tag, "/ready"}, m_ir, 1);
    @(posedge clk); #1;
    t_ivalid = 1'b0;
    chk({tag, "/busy"}, m_busy, 1);
    lat = 1;
    while (!m_ov && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, lat, (op == 3'd7) ? 9 : 1);
    chk({tag, "/result"}, m_res, e.res);
    chk({tag, "/zero"}, m_z, e.z);
    chk({tag, "/carry"}, m_c, e.c);
    @(posedge clk); #1;
    chk({tag, "/pulse"}, m_ov, 0);
    chk({tag, "/ready_back"}, m_ir, 1);
  endtask

  initial begin
    rst_n = 1'b0; t_ivalid = 1'b0; t_ordy = 1'b0;
    t_a = '0; t_b = '0; t_op = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int unsigned w = 8; w <= 16; w += 8) begin
      cur_w = w;
      #0;
      chk("rst/in_ready", m_ir, 1);
      chk("rst/out_valid", m_ov, 0);
      chk("rst/result", m_res, 0);
      chk("rst/zero", m_z, 0);
      chk("rst/carry", m_c, 0);
      chk("rst/busy", m_busy, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(8, 3'd7, 16'h0057, 16'h0083, "gf57x83");
    run(8, 3'd7, 16'h0057, 16'h0013, "gf57x13");
    run(8, 3'd3, 16'h00F0, 16'h0020, "add_carry");
    run(8, 3'd4, 16'h0005, 16'h0007, "sub_borrow");
    run(8, 3'd4, 16'h0007, 16'h0007, "sub_zero");
    run(16, 3'd7, 16'h5702, 16'h8387, "gf16_lanes");
    run(16, 3'd6, 16'h1234, 16'h0000, "rotl8_16");
    run(16, 3'd5, 16'h0001, 16'h0013, "shl_mod16");
    run(8, 3'd6, 16'h00A5, 16'h0000, "rotl8_8");

    // Backpressure: a second request stays asserted but must be ignored.
    cur_w = 8; t_op = 3'd2; t_a = 16'h00AA; t_b = 16'h00AA;
    t_ordy = 1'b0; t_ivalid = 1'b1;
    @(posedge clk); #1;
    t_op = 3'd3; t_a = 16'h0001; t_b = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      chk("bp/out_valid", m_ov, 1);
      chk("bp/result", m_res, 0);
      chk("bp/zero", m_z, 1);
      chk("bp/in_ready", m_ir, 0);
      @(posedge clk); #1;
    end
    t_ordy = 1'b1;
    @(posedge clk); #1;
    chk("bp/release_valid", m_ov, 0);
    chk("bp/release_ready", m_ir, 1);
    t_ivalid = 1'b0;
    @(posedge clk); #1;
    chk("bp/no_ghost", m_ov, 0);

    // Abort a GF multiply at count=4 with a nonzero prior result in place.
    run(8, 3'd1, 16'h00C3, 16'h0018, "pre_abort_or");
    cur_w = 8; t_op = 3'd7; t_a = 16'h0057; t_b = 16'h0083; t_ivalid = 1'b1;
    @(posedge clk); #1;
    t_ivalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort/out_valid", m_ov, 0);
    chk("abort/result", m_res, 0);
    chk("abort/in_ready", m_ir, 1);
    chk("abort/busy", m_busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(8, 3'd7, 16'h0002, 16'h0087, "gf_after_abort");

    for (int unsigned w = 8; w <= 16; w += 8)
      for (int op = 0; op < 8; op++)
        repeat (8) run(w, 3'(op), 16'($urandom), 16'($urandom), "rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
